// File: rtl/cp_pkg.sv
// Shared definitions for the cyclic-prefix inserter/remover pair.
package cp_pkg;
  localparam int unsigned CP_DATA_W  = 32;
  localparam int unsigned CP_LEN_W   = 16;
  localparam int unsigned CP_LEN_MAX = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DROP = 2'd1,
    ST_PASS = 2'd2,
    ST_ERR  = 2'd3
  } cp_state_e;
endpackage

// File: rtl/cp_out_stage.sv
// One-deep registered valid/ready output stage carrying a sample and its last flag.
module cp_out_stage #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              out_ready,
  output logic              in_ready_c,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              last
);
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  // A load may coincide with a drain; the new sample simply replaces the old one.
  always_comb begin
    in_ready_c = !valid_q || out_ready;
    data_d     = data_q;
    valid_d    = valid_q;
    last_d     = last_q;
    if (load) begin
      data_d  = load_data;
      valid_d = 1'b1;
      last_d  = load_last;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign last  = last_q;
endmodule

// File: rtl/cp_remove.sv
// Cyclic-prefix remover: drops cp_length prefix samples per symbol and forwards the body.
module cp_remove
  import cp_pkg::*;
#(
  parameter int unsigned DATA_W = CP_DATA_W,
  parameter int unsigned LEN_W  = CP_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] signal_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LEN_W-1:0]  cp_length,
  input  logic [LEN_W-1:0]  frame_length,
  output logic [DATA_W-1:0] signal_out,
  output logic              valid,
  input  logic              out_ready,
  output logic              last,
  output logic              cp_flag,
  output logic              error
);
  localparam int unsigned SUM_W = LEN_W + 1;

  cp_state_e          state_q, state_d;
  logic [LEN_W-1:0]   k_q, k_d;
  logic [LEN_W-1:0]   cp_q, cp_d;
  logic [LEN_W-1:0]   frame_q, frame_d;
  logic               error_q, error_d;

  logic               stage_ready_c;
  logic               load_c;
  logic               load_last_c;
  logic               in_xfer_c;
  logic               cfg_bad_c;
  logic               last_k_c;
  logic [SUM_W-1:0]   sym_end_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      cp_q    <= '0;
      frame_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cp_q    <= cp_d;
      frame_q <= frame_d;
      error_q <= error_d;
    end
  end

  // Handshake and classification; the k=0 sample is judged on the live config.
  always_comb begin
    cfg_bad_c   = (frame_length == '0) || (cp_length > frame_length);
    sym_end_c   = {1'b0, cp_q} + {1'b0, frame_q} - SUM_W'(1);
    last_k_c    = ({1'b0, k_q} == sym_end_c);
    in_ready    = 1'b0;
    cp_flag     = 1'b0;
    load_c      = 1'b0;
    load_last_c = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          if (cfg_bad_c) begin
            in_ready = 1'b1;
          end else if (cp_length != '0) begin
            in_ready = 1'b1;
            cp_flag  = in_valid;
          end else begin
            in_ready    = stage_ready_c;
            load_c      = in_valid && stage_ready_c;
            load_last_c = (frame_length == LEN_W'(1));
          end
        end
        ST_DROP: begin
          in_ready = 1'b1;
          cp_flag  = 1'b1;
        end
        ST_PASS: begin
          in_ready    = stage_ready_c;
          load_c      = in_valid && stage_ready_c;
          load_last_c = last_k_c;
        end
        default: ;
      endcase
    end
    in_xfer_c = in_valid && in_ready;
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cp_d    = cp_q;
    frame_d = frame_q;
    error_d = error_q;
    case (state_q)
      ST_IDLE: begin
        if (in_xfer_c) begin
          cp_d    = cp_length;
          frame_d = frame_length;
          if (cfg_bad_c) begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end else begin
            k_d = LEN_W'(1);
            // A one-sample symbol with no prefix completes on its k=0 sample.
            if ((cp_length == '0) && (frame_length == LEN_W'(1))) begin
              k_d = '0;
            end else if (cp_length > LEN_W'(1)) begin
              state_d = ST_DROP;
            end else begin
              state_d = ST_PASS;
            end
          end
        end
      end
      ST_DROP: begin
        if (in_xfer_c) begin
          k_d = k_q + LEN_W'(1);
          if (k_q == cp_q - LEN_W'(1)) begin
            state_d = ST_PASS;
          end
        end
      end
      ST_PASS: begin
        if (in_xfer_c) begin
          if (last_k_c) begin
            k_d     = '0;
            state_d = ST_IDLE;
          end else begin
            k_d = k_q + LEN_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  cp_out_stage #(.DATA_W(DATA_W)) u_out_stage (
    .clk        (clk),
    .rst        (rst),
    .load       (load_c),
    .load_data  (signal_in),
    .load_last  (load_last_c),
    .out_ready  (out_ready),
    .in_ready_c (stage_ready_c),
    .data       (signal_out),
    .valid      (valid),
    .last       (last)
  );

  assign error = error_q;
endmodule

// File: tb/tb_cp_remove.sv
// Self-checking bench for cp_remove: vector table, corner sequences and randomized symbols.
module tb_cp_remove;
  import cp_pkg::*;
  localparam int unsigned DW = CP_DATA_W;
  localparam int unsigned LW = CP_LEN_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] signal_in = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [LW-1:0] cp_length = '0;
  logic [LW-1:0] frame_length = LW'(1);
  logic [DW-1:0] signal_out;
  logic          valid;
  logic          out_ready = 1'b1;
  logic          last;
  logic          cp_flag;
  logic          error;

  cp_remove dut (
    .clk(clk), .rst(rst), .signal_in(signal_in), .in_valid(in_valid), .in_ready(in_ready),
    .cp_length(cp_length), .frame_length(frame_length), .signal_out(signal_out), .valid(valid),
    .out_ready(out_ready), .last(last), .cp_flag(cp_flag), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] d; int cp; int fr; } item_t;
  typedef struct { logic [DW-1:0] d; logic l; } out_t;
  typedef struct { int cp; int fr; int nsym; int rmode; int gap; int exp_out; bit exp_err; string name; } vec_t;

  item_t in_q[$], sent_q[$];
  out_t  cap_q[$], exp_q[$];
  int    out_cyc[$], acc_cyc[$];
  int    checks = 0, errors = 0, cyc = 0;
  int    flag_cnt = 0, first_valid_cyc = -1, next_d = 0;
  int    exp_drop, exp_acc;
  bit    exp_err;
  bit    stall_q = 1'b0;
  logic [DW-1:0] hold_d;
  logic  hold_l;

  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Output monitor: capture transfers, hold-while-stalled and no-overrun rules.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        checks++;
        if (!valid || signal_out !== hold_d || last !== hold_l) begin
          errors++;
          $display("FAIL hold: valid=%b data=%h last=%b expected valid=1 data=%h last=%b",
                   valid, signal_out, last, hold_d, hold_l);
        end
      end
      if (valid && !out_ready && in_valid && !cp_flag && frame_length != '0 && cp_length <= frame_length) begin
        checks++;
        if (in_ready) begin
          errors++;
          $display("FAIL overrun: in_ready=1 expected 0 while output stalled");
        end
      end
      if (valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (valid && out_ready) begin
        cap_q.push_back('{signal_out, last});
        out_cyc.push_back(cyc);
      end
      if (in_valid && in_ready && cp_flag) flag_cnt++;
      stall_q = valid && !out_ready;
      hold_d  = signal_out;
      hold_l  = last;
    end
  end

  task automatic clear_all();
    in_q.delete(); sent_q.delete(); cap_q.delete(); out_cyc.delete(); acc_cyc.delete();
    flag_cnt = 0; first_valid_cyc = -1; next_d = 0;
  endtask

  // Called at time 0 or just after a rising edge.
  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_valid", int'(valid), 0);
    chk("rst_last", int'(last), 0);
    chk("rst_cp_flag", int'(cp_flag), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_data", int'(signal_out), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_all();
  endtask

  task automatic push_item(input int cp, input int fr);
    item_t it;
    it.d = DW'(next_d); it.cp = cp; it.fr = fr;
    next_d++;
    in_q.push_back(it); sent_q.push_back(it);
  endtask

  // One symbol; live config on non-first samples is either held or scrambled.
  task automatic add_sym(input int cp, input int fr, input bit scramble);
    int n = cp + fr + 2;
    if (fr != 0 && cp <= fr) n = cp + fr;
    for (int p = 0; p < n; p++) begin
      if (p == 0 || !scramble) push_item(cp, fr);
      else push_item($urandom_range(0, 15), $urandom_range(0, 15));
    end
  endtask

  task automatic run(input int budget, input int rmode, input int gap, input int max_acc, output bit tmo);
    int  n = 0, acc = 0;
    bit  done = 1'b0, took;
    tmo = 1'b0;
    while (!done) begin
      @(posedge clk); #1;
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (in_q.size() > 0 && acc < max_acc && $urandom_range(0, 99) >= gap) begin
        in_valid = 1'b1; signal_in = in_q[0].d;
        cp_length = LW'(in_q[0].cp); frame_length = LW'(in_q[0].fr);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      took = in_valid && in_ready;
      if (took) begin void'(in_q.pop_front()); acc++; acc_cyc.push_back(cyc); end
      n++;
      if (acc >= max_acc) done = 1'b1;
      else if (in_q.size() == 0 && !valid && !took) done = 1'b1;
      if (n >= budget) begin tmo = 1'b1; done = 1'b1; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  // Reference: walk the sent samples symbol by symbol using the stated rules.
  task automatic model();
    int pos = 0, cp = 0, fr = 0;
    exp_q.delete(); exp_drop = 0; exp_acc = 0; exp_err = 1'b0;
    foreach (sent_q[i]) begin
      if (pos == 0) begin
        cp = sent_q[i].cp; fr = sent_q[i].fr;
        if (fr == 0 || cp > fr) begin exp_acc++; exp_err = 1'b1; break; end
      end
      exp_acc++;
      if (pos < cp) exp_drop++;
      else exp_q.push_back('{sent_q[i].d, (pos == cp + fr - 1)});
      pos = (pos == cp + fr - 1) ? 0 : pos + 1;
    end
  endtask

  task automatic verify(input string name, input bit tmo);
    int n;
    model();
    chk({name, "_accepted"}, acc_cyc.size(), exp_acc);
    chk({name, "_outputs"}, cap_q.size(), exp_q.size());
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({name, "_data"}, int'(cap_q[i].d), int'(exp_q[i].d));
      chk({name, "_last"}, int'(cap_q[i].l), int'(exp_q[i].l));
    end
    chk({name, "_cp_flag_count"}, flag_cnt, exp_drop);
    chk({name, "_error"}, int'(error), int'(exp_err));
    if (exp_err) chk({name, "_err_in_ready"}, int'(in_ready), 0);
    else chk({name, "_timeout"}, int'(tmo), 0);
  endtask

  vec_t vecs[$];

  initial begin
    bit tmo;
    int gaps;
    vecs.push_back('{4, 16, 1, 0, 0, 16, 1'b0, "cp4_f16"});
    vecs.push_back('{2, 8, 3, 0, 0, 24, 1'b0, "cp2_f8_x3"});
    vecs.push_back('{2, 8, 2, 1, 0, 16, 1'b0, "toggle_ready"});
    vecs.push_back('{0, 4, 1, 0, 0, 4, 1'b0, "cp0_f4"});
    vecs.push_back('{4, 4, 2, 0, 0, 8, 1'b0, "cp_eq_frame"});
    vecs.push_back('{0, 1, 3, 2, 30, 3, 1'b0, "cp0_f1"});
    vecs.push_back('{1, 3, 2, 2, 20, 6, 1'b0, "cp1_f3"});
    vecs.push_back('{9, 8, 1, 0, 0, 0, 1'b1, "cp_gt_frame"});
    vecs.push_back('{0, 0, 1, 0, 0, 0, 1'b1, "frame0"});
    vecs.push_back('{3, 5, 1, 0, 0, 5, 1'b0, "after_err"});

    foreach (vecs[v]) begin
      do_reset();
      for (int s = 0; s < vecs[v].nsym; s++) add_sym(vecs[v].cp, vecs[v].fr, 1'b0);
      run(vecs[v].exp_err ? 60 : 400, vecs[v].rmode, vecs[v].gap, 1 << 30, tmo);
      chk({vecs[v].name, "_count"}, cap_q.size(), vecs[v].exp_out);
      verify(vecs[v].name, tmo);
      if (v == 0 && acc_cyc.size() > 4 && cap_q.size() > 0) begin
        chk("latency", first_valid_cyc, acc_cyc[4] + 1);
        chk("first_data", int'(cap_q[0].d), 4);
      end
      if (vecs[v].rmode == 0 && vecs[v].gap == 0 && !vecs[v].exp_err) begin
        gaps = 0;
        for (int i = 1; i < out_cyc.size(); i++)
          if (!cap_q[i-1].l && out_cyc[i] != out_cyc[i-1] + 1) gaps++;
        chk({vecs[v].name, "_gaps"}, gaps, 0);
      end
    end

    // Config change mid-symbol only applies from the next k=0.
    do_reset();
    push_item(0, 4); push_item(0, 4); push_item(3, 4); push_item(3, 4);
    add_sym(3, 4, 1'b0);
    run(400, 0, 0, 1 << 30, tmo);
    chk("mid_cfg_outputs", cap_q.size(), 8);
    chk("mid_cfg_flags", flag_cnt, 3);
    verify("mid_cfg", tmo);

    // Reset in the middle of a symbol abandons it completely.
    do_reset();
    add_sym(4, 16, 1'b0);
    run(400, 0, 0, 6, tmo);
    chk("pre_rst_valid", int'(valid), 1);
    do_reset();
    next_d = 100;
    add_sym(4, 16, 1'b0);
    run(400, 0, 0, 1 << 30, tmo);
    chk("post_rst_outputs", cap_q.size(), 16);
    chk("post_rst_flags", flag_cnt, 4);
    verify("post_rst", tmo);

    // Randomized multi-symbol streams with scrambled mid-symbol config.
    for (int it = 0; it < 12; it++) begin
      int nsym = $urandom_range(1, 3);
      do_reset();
      for (int s = 0; s < nsym; s++) begin
        int cp = $urandom_range(0, 6);
        int fr = $urandom_range((cp == 0) ? 1 : cp, 8);
        add_sym(cp, fr, 1'b1);
      end
      if ($urandom_range(0, 3) == 0) add_sym($urandom_range(5, 9), $urandom_range(0, 4), 1'b0);
      run(300, 2, 20, 1 << 30, tmo);
      verify("random", tmo);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
